// File: rtl/stopwatch_display.sv
// stopwatch_display: scans four BCD stopwatch digits onto a common-anode 4-digit 7-seg as M.SS.t
// with per-frame snapshots, an anti-ghosting guard, leading-zero blanking and a game-over blink.
module stopwatch_display #(
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD        = 500,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [3:0] hex0,
  input  logic [3:0] hex1,
  input  logic [3:0] hex2,
  input  logic [3:0] hex3,
  input  logic       Kill,
  input  logic       Lz_blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_FRAMES) + 1;
  typedef enum logic {ON, OFF} blink_t;
  blink_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  logic [3:0][3:0] snap;
  logic [BW-1:0] blink_cnt, blink_cnt_nx;
  logic slot_end, boundary, last, dark;
  logic [3:0] digit, an_nx;
  logic [6:0] seg_nx;
  logic dp_nx;
  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction
  assign slot_end = cnt == CW'(SCAN_DIV - 1);
  assign boundary = slot_end && idx == 2'd3;
  assign last = blink_cnt == BW'(BLINK_FRAMES - 1);
  // Kill low pins the FSM in ON so a new game-over always starts with a full lit half-period
  always_comb begin
    state_nx = !Kill ? ON : (boundary && last) ? ((state == ON) ? OFF : ON) : state;
    blink_cnt_nx = (!Kill || (boundary && last)) ? '0 : blink_cnt + {{(BW-1){1'b0}}, boundary};
  end
  always_comb begin
    digit = snap[idx];
    dark = (cnt < CW'(GUARD)) || state == OFF || (idx == 2'd3 && Lz_blank && digit == 4'd0);
    an_nx = dark ? 4'hF : ~(4'b0001 << idx);
    seg_nx = dark ? 7'h7F : enc(digit);
    dp_nx = dark | ~idx[0];
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      cnt <= '0;
      idx <= '0;
      snap <= '0;
      state <= ON;
      blink_cnt <= '0;
      an <= 4'hF;
      seg <= 7'h7F;
      dp <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      idx <= idx + {1'b0, slot_end};
      if (boundary) snap <= {hex3, hex2, hex1, hex0};
      state <= state_nx;
      blink_cnt <= blink_cnt_nx;
      an <= an_nx;
      seg <= seg_nx;
      dp <= dp_nx;
      frame_tick <= boundary;
    end
endmodule
